// File: rtl/crc5_calc.sv
// USB CRC5 serializer: loads a packet of up to 100 bits, shifts it out
// LSB first, then appends the inverted CRC5 of the bits after the PID.
// Ports:
//   clock, reset_n     rising-edge clock, async active-low reset
//   pkt_ready          load strobe from the protocol handler (IDLE only)
//   bs_ready           bit stuffer accepts out_bit this cycle
//   pkt_in[99:0]       packet bits, bit 0 sent first, [7:0] is the PID
//   pkt_len[31:0]      number of valid bits in pkt_in (1..100)
//   out_bit            serial bit to the bit stuffer
//   crc_valid_out      out_bit is valid this cycle
module crc5_calc (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pkt_ready,
  input  logic        bs_ready,
  input  logic [99:0] pkt_in,
  input  logic [31:0] pkt_len,
  output logic        out_bit,
  output logic        crc_valid_out
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    FLUSH
  } state_t;

  state_t      state_q, state_d;
  logic [99:0] pkt_q, pkt_d;
  logic [31:0] len_q, len_d;
  logic [6:0]  idx_q, idx_d;
  logic [4:0]  crc_q, crc_d;
  logic [2:0]  fcnt_q, fcnt_d;

  logic [4:0] crc_result;
  logic [2:0] crc_flush_cnt;
  logic       cur_bit;
  logic       fb;
  logic       last_bit;

  assign crc_result    = crc_q;
  assign crc_flush_cnt = fcnt_q;

  assign cur_bit  = pkt_q[idx_q];
  assign fb       = crc_q[4] ^ cur_bit;
  assign last_bit = ({25'd0, idx_q} == (len_q - 32'd1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pkt_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      crc_q   <= 5'b11111;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pkt_q   <= pkt_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      crc_q   <= crc_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pkt_d         = pkt_q;
    len_d         = len_q;
    idx_d         = idx_q;
    crc_d         = crc_q;
    fcnt_d        = fcnt_q;
    out_bit       = 1'b0;
    crc_valid_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pkt_ready) begin
          pkt_d   = pkt_in;
          len_d   = pkt_len;
          idx_d   = '0;
          crc_d   = 5'b11111;
          state_d = SEND;
        end
      end
      SEND: begin
        out_bit       = cur_bit;
        crc_valid_out = bs_ready;
        if (bs_ready) begin
          idx_d = idx_q + 7'd1;
          // PID bits are not covered by the CRC
          if (idx_q >= 7'd8) begin
            crc_d = {crc_q[3:0], 1'b0} ^
                    (fb ? 5'b00101 : 5'b00000);
          end
          if (last_bit) begin
            if (len_q > 32'd8) begin
              state_d = FLUSH;
              fcnt_d  = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      FLUSH: begin
        // inverted CRC, MSB first
        out_bit       = ~crc_q[3'd4 - fcnt_q];
        crc_valid_out = bs_ready;
        if (bs_ready) begin
          fcnt_d = fcnt_q + 3'd1;
          if (fcnt_q == 3'd4) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_crc5_calc.sv
// Self-checking bench for crc5_calc: scoreboard of expected serial bits,
// known USB token vectors, stalls, re-arm and mid-packet reset.
module tb_crc5_calc;

  logic        clock;
  logic        reset_n;
  logic        pkt_ready;
  logic        bs_ready;
  logic [99:0] pkt_in;
  logic [31:0] pkt_len;
  logic        out_bit;
  logic        crc_valid_out;

  int total;
  int bad;

  bit          exp_q[$];
  logic [23:0] cap;
  int          cnt;

  crc5_calc dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .pkt_ready     (pkt_ready),
    .bs_ready      (bs_ready),
    .pkt_in        (pkt_in),
    .pkt_len       (pkt_len),
    .out_bit       (out_bit),
    .crc_valid_out (crc_valid_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard monitor: every valid bit must match the head of the queue
  always @(negedge clock) begin
    if (reset_n && crc_valid_out) begin
      bit e;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got bit %0b, required no valid bit", out_bit);
      end else begin
        e = exp_q.pop_front();
        if (out_bit !== e) begin
          bad++;
          $display("FAIL sb_bit: got %0b, required %0b (bit %0d)",
                   out_bit, e, cnt);
        end
      end
      cap = {out_bit, cap[23:1]};
      cnt++;
    end
  end

  task automatic push_exp(input logic [99:0] p, input int len);
    logic [4:0] c;
    c = 5'b11111;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(p[i]);
      if (i >= 8) begin
        if (c[4] ^ p[i]) c = (c << 1) ^ 5'b00101;
        else             c = c << 1;
      end
    end
    if (len > 8) begin
      for (int k = 4; k >= 0; k--) exp_q.push_back(~c[k]);
    end
  endtask

  task automatic load(input logic [99:0] p, input int len);
    push_exp(p, len);
    cap = '0;
    cnt = 0;
    @(posedge clock);
    #1;
    pkt_in    = p;
    pkt_len   = len;
    pkt_ready = 1'b1;
    @(posedge clock);
    #1;
    pkt_ready = 1'b0;
  endtask

  task automatic drain(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clock);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    pkt_ready = 1'b0;
    bs_ready  = 1'b1;
    pkt_in    = '0;
    pkt_len   = 32'd1;
    #12;
    total++;
    if ({out_bit, crc_valid_out} !== 2'b00) begin
      bad++;
      $display("FAIL reset_out: got %b, required 00",
               {out_bit, crc_valid_out});
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    total++;
    if (crc_valid_out !== 1'b0) begin
      bad++;
      $display("FAIL idle_valid: got %0b, required 0", crc_valid_out);
    end
  endtask

  task automatic test_out_token;
    bit ok;
    bs_ready = 1'b1;
    load(100'b0100_0000101_11100001, 19);
    drain(ok);
    @(negedge clock);
    total++;
    if (!ok || cap !== 24'b10000_0100_0000101_11100001) begin
      bad++;
      $display("FAIL out_token_cap: got %b, required %b", cap,
               24'b10000_0100_0000101_11100001);
    end
    total++;
    if (cnt !== 24) begin
      bad++;
      $display("FAIL out_token_cnt: got %0d, required 24", cnt);
    end
    total++;
    if (crc_valid_out !== 1'b0) begin
      bad++;
      $display("FAIL out_token_idle: got %0b, required 0", crc_valid_out);
    end
  endtask

  task automatic test_tokens;
    bit ok;
    bs_ready = 1'b1;
    load(100'b1000_0000101_11100001, 19);
    drain(ok);
    @(negedge clock);
    total++;
    if (!ok || cap[23:19] !== 5'b01110) begin
      bad++;
      $display("FAIL endp8_crc: got %b, required 01110", cap[23:19]);
    end
    load(100'b1000_0000101_01101001, 19);
    drain(ok);
    @(negedge clock);
    total++;
    if (!ok || cap[23:19] !== 5'b01110) begin
      bad++;
      $display("FAIL in_crc: got %b, required 01110", cap[23:19]);
    end
    total++;
    if (cap[7:0] !== 8'h69) begin
      bad++;
      $display("FAIL in_pid: got %h, required 69", cap[7:0]);
    end
  endtask

  task automatic test_handshake;
    bit ok;
    bs_ready = 1'b1;
    load(100'hD2, 8);
    drain(ok);
    repeat (3) @(negedge clock);
    total++;
    if (!ok || cnt !== 8 || cap[23:16] !== 8'hD2) begin
      bad++;
      $display("FAIL handshake: got cnt=%0d bits=%h, required 8 D2",
               cnt, cap[23:16]);
    end
  endtask

  task automatic test_stall;
    bit   have;
    logic held;
    int   guard;
    have     = 1'b0;
    held     = 1'b0;
    bs_ready = 1'b0;
    load(100'b0100_0000101_11100001, 19);
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      #1;
      bs_ready = ~bs_ready;
      @(negedge clock);
      if (!bs_ready) begin
        total++;
        if (crc_valid_out !== 1'b0) begin
          bad++;
          $display("FAIL stall_valid: got %0b, required 0", crc_valid_out);
        end
        held = out_bit;
        have = 1'b1;
      end else if (have && crc_valid_out) begin
        total++;
        if (out_bit !== held) begin
          bad++;
          $display("FAIL stall_hold: got %0b, required %0b", out_bit, held);
        end
      end
      @(posedge clock);
      guard++;
    end
    bs_ready = 1'b1;
    @(negedge clock);
    total++;
    if (exp_q.size() != 0 || cap !== 24'b10000_0100_0000101_11100001) begin
      bad++;
      $display("FAIL stall_cap: got %b, required %b", cap,
               24'b10000_0100_0000101_11100001);
    end
  endtask

  task automatic test_back_to_back;
    bit          ok;
    logic [99:0] p;
    int          lens[4] = '{9, 100, 1, 37};
    bs_ready = 1'b1;
    foreach (lens[n]) begin
      p = '0;
      for (int i = 0; i < 100; i++) p[i] = 1'($urandom_range(0, 1));
      load(p, lens[n]);
      // a load strobe while busy must be ignored
      if (n == 1) begin
        repeat (3) @(posedge clock);
        #1;
        pkt_in    = ~p;
        pkt_len   = 32'd50;
        pkt_ready = 1'b1;
        @(posedge clock);
        #1;
        pkt_ready = 1'b0;
      end
      drain(ok);
      @(negedge clock);
      total++;
      if (!ok || cnt !== lens[n] + (lens[n] > 8 ? 5 : 0)) begin
        bad++;
        $display("FAIL b2b_len%0d: got %0d bits, required %0d", lens[n],
                 cnt, lens[n] + (lens[n] > 8 ? 5 : 0));
      end
    end
  endtask

  task automatic test_reset_flush;
    bit ok;
    int guard;
    bs_ready = 1'b1;
    load(100'b0100_0000101_11100001, 19);
    guard = 0;
    while (exp_q.size() > 3 && guard < 100) begin
      @(posedge clock);
      guard++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    total++;
    if (exp_q.size() != 3 || {out_bit, crc_valid_out} !== 2'b00) begin
      bad++;
      $display("FAIL reset_flush: got %b left=%0d, required 00 left=3",
               {out_bit, crc_valid_out}, exp_q.size());
    end
    exp_q.delete();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    load(100'b1000_0000101_01101001, 19);
    drain(ok);
    @(negedge clock);
    total++;
    if (!ok || cnt !== 24 || cap[23:19] !== 5'b01110) begin
      bad++;
      $display("FAIL after_reset: got cnt=%0d crc=%b, required 24 01110",
               cnt, cap[23:19]);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cap   = '0;
    cnt   = 0;
    test_reset();
    test_out_token();
    test_tokens();
    test_handshake();
    test_stall();
    test_back_to_back();
    test_reset_flush();
    repeat (3) @(negedge clock);
    total++;
    if (exp_q.size() != 0 || crc_valid_out !== 1'b0) begin
      bad++;
      $display("FAIL final_idle: left=%0d valid=%0b, required 0 0",
               exp_q.size(), crc_valid_out);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc5_calc.md
Name: crc5_calc

Overview:
- Serializer and USB CRC5 generator between the protocol handler (PH) and the bit stuffer (BS).
- Accepts a packet of up to 100 bits in one cycle and sends it out serially, LSB first.
- Computes CRC5 over every bit after the 8-bit PID, then appends the complemented CRC5, highest-order bit first.
- Packets of 8 bits or fewer are sent with no CRC.

Parameters:
- None. Polynomial x^5+x^2+1, seed 5'b11111, PID length 8, and buffer width 100 are fixed.

Ports:
- clock, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- pkt_ready, input, 1, PH presents a valid packet this cycle (load strobe).
- bs_ready, input, 1, BS accepts one bit this cycle.
- pkt_in, input, 100, packet bits; bit 0 is sent first; bits [7:0] are the PID.
- pkt_len, input, 32, number of valid bits in pkt_in (1..100).
- out_bit, output, 1, serial bit to BS.
- crc_valid_out, output, 1, out_bit is valid this cycle.

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clock.
- Reset values: state IDLE, crc_result = 5'b11111, crc_flush_cnt = 0, bit counter = 0, out_bit = 0, crc_valid_out = 0.
- States: IDLE, SEND, FLUSH.
- IDLE:
  - pkt_ready=1 at a rising edge latches pkt_in and pkt_len, resets the bit index to 0, seeds crc_result to 5'b11111, and enters SEND.
  - pkt_ready is ignored outside IDLE.
- SEND:
  - out_bit = latched_pkt[idx]; crc_valid_out = bs_ready.
  - On an edge with bs_ready=1, idx increments.
  - If idx >= 8, the CRC updates with d = the current bit: fb = crc_result[4]^d; crc_result = {crc_result[3:0],1'b0} ^ (fb ? 5'b00101 : 5'b00000).
  - When idx == pkt_len-1 and the bit is accepted:
    - if pkt_len > 8, go to FLUSH with crc_flush_cnt = 0;
    - otherwise go to IDLE.
- FLUSH:
  - out_bit = ~crc_result[4 - crc_flush_cnt]; crc_valid_out = bs_ready; crc_result is frozen.
  - On an edge with bs_ready=1, crc_flush_cnt increments. After crc_flush_cnt == 4 is accepted, go to IDLE.
- bs_ready=0 stalls: idx, crc_result and crc_flush_cnt hold, out_bit holds, crc_valid_out = 0.
- Outputs are combinational from registered state; first bit is valid in the cycle after the pkt_ready edge.
- With bs_ready held high, a 19-bit token produces 24 consecutive valid bits.
- In IDLE: out_bit = 0, crc_valid_out = 0.
- Re-arm: IDLE is entered on the edge after the last bit. A new pkt_ready is honoured from the following edge, giving at least one idle cycle between packets.
- pkt_len of 0 or greater than 100 is illegal and must not be driven.
- Reset asserted mid-packet aborts immediately to reset values; no partial CRC is emitted.
- Expose crc_result[4:0] and crc_flush_cnt[2:0] as named internal signals for debug.

Test Plan:
- OUT token: pkt_in = 19'b0100_0000101_11100001 (PID 0xE1, addr 5, ENDP 4), pkt_len = 19, one-cycle pkt_ready, bs_ready = 1.
  - Required: 24 bits with crc_valid_out = 1; the last 5 bits are 0,0,0,0,1.
  - A right-shifting 24-bit capture register ends at 24'b10000_0100_0000101_11100001.
  - crc_valid_out is 0 afterwards.
- OUT token, ENDP 8: pkt_in = 19'b1000_0000101_11100001, len 19 → CRC5 bits 0,1,1,1,0 (reads 0x0E).
- IN token: pkt_in = 19'b1000_0000101_01101001 → same CRC bits 0,1,1,1,0; PID bits sent 1,0,0,1,0,1,1,0.
- Handshake: pkt_len = 8, pkt_in = 8'hD2 → exactly 8 valid bits 0,1,0,0,1,0,1,1, no CRC, then IDLE.
- Stall: first OUT token with bs_ready toggled 0/1 every cycle → same 24-bit sequence. crc_valid_out = 0 on every stalled cycle and out_bit is stable across each stall.
- Reset mid-FLUSH: assert reset_n low → outputs go to 0 asynchronously. A subsequent packet transmits correctly from a fresh seed.
